// File: rtl/cache_set_assoc.sv
// N-way set-associative tag/lookup model with true-LRU replacement, flush and
// saturating hit/miss statistics. One lookup per cycle, response one cycle later.
module cache_set_assoc #(
  parameter int ADDR_W   = 11,
  parameter int OFFSET_W = 4,
  parameter int SET_W    = 3,
  parameter int WAYS     = 2,
  parameter int CNT_W    = 16,
  parameter logic [ADDR_W-1:0] MISS_DATA = 11'h3F3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   read,
  input  logic [ADDR_W-1:0]                      addr,
  input  logic                                   flush,
  input  logic                                   clr_stats,
  output logic                                   resp_valid,
  output logic                                   hit,
  output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] way,
  output logic [ADDR_W-1:0]                      read_data,
  output logic [CNT_W-1:0]                       hit_count,
  output logic [CNT_W-1:0]                       miss_count
);

  localparam int TAG_W = ADDR_W - OFFSET_W - SET_W;
  localparam int SETS  = 1 << SET_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAY_W-1:0] age_q   [SETS][WAYS];

  logic [SET_W-1:0] set_idx;
  logic [TAG_W-1:0] addr_tag;
  logic             hit_any;
  logic             inv_any;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] acc_way;
  logic [WAY_W-1:0] acc_age;

  assign set_idx  = addr[OFFSET_W +: SET_W];
  assign addr_tag = addr[ADDR_W-1 -: TAG_W];

  // Victim priority: matching way, else lowest invalid way, else oldest way.
  always_comb begin
    hit_any = 1'b0;
    inv_any = 1'b0;
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == addr_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[set_idx][w] && !inv_any) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_q[set_idx][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    acc_way = hit_any ? hit_way : (inv_any ? inv_way : lru_way);
    acc_age = age_q[set_idx][acc_way];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          age_q[s][w] <= WAY_W'(w);
        end
      end
      resp_valid <= 1'b0;
      hit        <= 1'b0;
      way        <= '0;
      read_data  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (flush) begin
        for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (read) begin
        resp_valid                <= 1'b1;
        hit                       <= hit_any;
        way                       <= acc_way;
        read_data                 <= hit_any ? addr : MISS_DATA;
        valid_q[set_idx][acc_way] <= 1'b1;
        tag_q[set_idx][acc_way]   <= addr_tag;
        // Ages stay a permutation: only ways younger than the accessed one age.
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == acc_way)
            age_q[set_idx][w] <= '0;
          else if (age_q[set_idx][w] < acc_age)
            age_q[set_idx][w] <= age_q[set_idx][w] + WAY_W'(1);
        end
      end

      if (clr_stats) begin
        hit_count  <= '0;
        miss_count <= '0;
      end else if (read && !flush) begin
        if (hit_any) begin
          if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
        end else begin
          if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/cache_set_assoc.md
# cache_set_assoc

Parametrised N-way set-associative cache tag/lookup model, the next-generation replacement for the team's direct-mapped lookup block. It accepts one read lookup per cycle and returns hit/miss, the serving way and dummy data one cycle later. It adds configurable geometry, true-LRU replacement, a flush command and saturating hit/miss statistics counters. It sits in the cache simulator datapath between the address stimulus generator and the statistics/scoreboard logic.

## Interface
- ADDR_W, 11: address width in bits.
- OFFSET_W, 4: block-offset bits (block = 2^OFFSET_W bytes).
- SET_W, 3: set-index bits (2^SET_W sets); must satisfy OFFSET_W+SET_W < ADDR_W.
- WAYS, 2: associativity; legal values 1, 2, 4.
- CNT_W, 16: statistics counter width.
- MISS_DATA, 11'h3F3: value driven on read_data on a miss (ADDR_W wide).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- read  in  1  lookup strobe; one lookup per cycle when high.
- addr  in  ADDR_W  lookup address.
- flush  in  1  invalidate all lines (one-cycle command).
- clr_stats  in  1  clear hit_count/miss_count.
- resp_valid  out  1  response valid, one cycle after accepted read.
- hit  out  1  1 = hit, 0 = miss; qualified by resp_valid.
- way  out  max(1,log2(WAYS))  way that hit or was filled.
- read_data  out  ADDR_W  addr echoed on hit, MISS_DATA on miss.
- hit_count  out  CNT_W  saturating hit total.
- miss_count  out  CNT_W  saturating miss total.

## Operation
- Address split: offset = addr[OFFSET_W-1:0]; set = addr[OFFSET_W +: SET_W]; tag = addr[ADDR_W-1 : OFFSET_W+SET_W] (TAG_W = ADDR_W-OFFSET_W-SET_W).
- State per set per way: valid bit, TAG_W tag, log2(WAYS)-bit LRU age (0 = most recent). Ages within a set are always a permutation of 0..WAYS-1.
- Lookup: hit when any way in the set is valid with matching tag; at most one can match.
- Hit: hit=1, way=matching way, read_data=addr, hit_count+1.
- Miss: victim = lowest-index invalid way; if none, way whose age = WAYS-1. Write tag, set valid. hit=0, way=victim, read_data=MISS_DATA, miss_count+1.
- LRU update on every accepted read (hit or fill): accessed way age←0; every way in that set whose age < accessed way's old age increments by 1; others unchanged.
- WAYS=1: behaves as direct-mapped; way output is constant 0, ages unused.
- flush: clears all valid bits; tags and ages retained; counters unchanged. flush and read in the same cycle: flush wins, read dropped (resp_valid=0, counters unchanged).
- clr_stats: counters ←0 on that edge; a read in the same cycle still responds but is not counted.
- Counters saturate at 2^CNT_W-1; no wrap.

## Timing
- Reset: all valid=0, tags=0, ages of way w = w in every set; resp_valid=0, hit=0, way=0, read_data=0, hit_count=0, miss_count=0. rst overrides read/flush/clr_stats.
- Latency: read sampled at edge N → resp_valid/hit/way/read_data valid after edge N, held until next edge. resp_valid=0 in cycles with no accepted read; hit/way/read_data then hold previous values.
- Back-to-back reads to the same set: read at N+1 sees tag/valid/age state written at N (a miss-fill at N makes the same address hit at N+1).
- Counters update on the same edge as the response.
- Reset asserted mid-stream: next-edge state is reset state; a read in that cycle is discarded.

## Test plan
Defaults (TAG_W=4; 0x010, 0x090, 0x110 all map to set 1 with tags 0, 1, 2).
- Reset, then read 0x010 → resp_valid=1, hit=0, way=0, read_data=0x3F3; read 0x010 next cycle → hit=1, way=0, read_data=0x010; hit_count=1, miss_count=1.
- Reads 0x010, 0x090, 0x010, 0x110 → miss w0, miss w1, hit w0, miss w1 (evicts 0x090); then 0x090 → miss w0 (LRU).
- Fill 0x010, 0x090; flush with read 0x010 same cycle → resp_valid=0; read 0x010 next → hit=0, way=0; counters reflect only counted reads.
- CNT_W=4: 16 hits to 0x010 after fill → hit_count saturates at 15; clr_stats → 0; read in clr_stats cycle not counted.
- WAYS=4: tags 0..4 in set 1 → four fills way 0..3, fifth evicts way 0; re-access order check against LRU ages.
- rst asserted for one cycle mid-stream with read=1 → all outputs 0 next cycle, prior lines miss afterwards.
